// File: rtl/square_wave_controller.sv
// Programmable square-wave burst sequencer with start/stop and busy/done handshake.
// Optional macro SQW_DUTY_EN adds a separate low_period input for arbitrary duty cycle.
module square_wave_controller #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] num_cycles,
`ifdef SQW_DUTY_EN
    input  logic [CNT_W-1:0]   low_period,
`endif
    output logic               signal,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   l_q, l_d;
    logic [BURST_W-1:0] n_q, n_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic               signal_q, signal_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               stop_pend_q, stop_pend_d;

    logic [CNT_W-1:0]   h_in;
    logic [CNT_W-1:0]   l_in;
    logic [BURST_W-1:0] count_inc;
    logic               last_period;

    // Phase lengths of zero are clamped to one clock.
    assign h_in = (half_period == '0) ? CNT_W'(1) : half_period;
`ifdef SQW_DUTY_EN
    assign l_in = (low_period == '0) ? CNT_W'(1) : low_period;
`else
    assign l_in = h_in;
`endif

    assign count_inc   = count_q + BURST_W'(1);
    assign last_period = ((n_q != '0) && (count_inc == n_q)) || stop_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            h_q         <= '0;
            l_q         <= '0;
            n_q         <= '0;
            count_q     <= '0;
            signal_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            h_q         <= h_d;
            l_q         <= l_d;
            n_q         <= n_d;
            count_q     <= count_d;
            signal_q    <= signal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        h_d         = h_q;
        l_d         = l_q;
        n_d         = n_q;
        count_d     = count_q;
        signal_d    = signal_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;

        case (state_q)
            IDLE: begin
                // Stop is ignored here, even alongside start.
                if (start) begin
                    h_d         = h_in;
                    l_d         = l_in;
                    n_d         = num_cycles;
                    cnt_d       = h_in - CNT_W'(1);
                    count_d     = '0;
                    signal_d    = 1'b1;
                    busy_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = HIGH;
                end
            end
            HIGH: begin
                stop_pend_d = stop_pend_q | stop;
                if (cnt_q == '0) begin
                    cnt_d    = l_q - CNT_W'(1);
                    signal_d = 1'b0;
                    state_d  = LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                stop_pend_d = stop_pend_q | stop;
                if (cnt_q == '0) begin
                    count_d = count_inc;
                    if (last_period) begin
                        signal_d    = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d    = h_q - CNT_W'(1);
                        signal_d = 1'b1;
                        state_d  = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign signal      = signal_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = count_q;

endmodule

// File: doc/square_wave_controller.md
Name: square_wave_controller

Overview:
Clocked, programmable square-wave sequencer. It drives one square-wave output with a configurable half-period and a configurable number of periods (finite burst or continuous), under start/stop control. It replaces free-running delay-based toggling with synthesizable timing. Upstream control logic uses the busy/done handshake to sequence successive bursts.

Parameters:
CNT_W, 16, width of the phase-length counter and of half_period / low_period
BURST_W, 8, width of num_cycles and cycle_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level-sampled request to begin a burst; acted on only in IDLE
stop  input  1  graceful stop request; acted on only while busy
half_period  input  CNT_W  high-phase length in clocks; also the low-phase length unless SQW_DUTY_EN is defined; 0 is treated as 1
num_cycles  input  BURST_W  number of full periods; 0 = continuous until stop
low_period  input  CNT_W  low-phase length in clocks (present only with SQW_DUTY_EN); 0 is treated as 1
signal  output  1  generated square wave, registered
busy  output  1  high from the first high phase through the last low phase
done  output  1  one-clock pulse after a burst completes or after a stop completes
cycle_count  output  BURST_W  periods completed in the current or most recent burst

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: signal=0, busy=0, done=0, cycle_count=0, state=IDLE, phase counter=0, stop_pending=0.
- States: IDLE, HIGH, LOW.
- IDLE to HIGH:
  - Trigger: start=1 sampled at edge N.
  - Latch half_period, num_cycles and low_period into shadow registers; they are held for the whole burst.
  - At edge N: signal=1, busy=1, cycle_count=0, phase counter loaded with (H-1), where H = max(half_period,1).
- HIGH:
  - Counter decrements each clock.
  - When counter=0: go to LOW, signal=0, counter loaded with (L-1).
  - L = H without SQW_DUTY_EN; L = max(low_period,1) with it.
- LOW:
  - When counter=0, the period ends and cycle_count increments (wraps modulo 2^BURST_W in continuous mode).
  - If (num_cycles!=0 and new count==num_cycles) or stop_pending: go to IDLE, signal=0, busy=0, done=1 for one clock, stop_pending cleared.
  - Otherwise: go to HIGH, signal=1, counter reloaded with (H-1).
- Resulting waveform:
  - signal is high for exactly H clocks and low for exactly L clocks.
  - busy falls on the same edge the final low phase ends.
  - Back-to-back bursts: a start held high in the cycle done=1 begins a new burst on the next edge, so the minimum IDLE gap is 1 clock.
- stop:
  - Stop is graceful. Any stop=1 while busy sets stop_pending, and the current period always completes.
  - stop in IDLE is ignored.
  - stop and start asserted together in IDLE: start wins; stop is ignored.
- Ignored while busy: start, and changes to any configuration input.
- Reset mid-burst: all outputs return to their reset values immediately (asynchronous). No done pulse is issued.
- cycle_count holds its final value in IDLE until the next start.

Optional Feature:
- Macro: SQW_DUTY_EN.
- Defined: the low_period port exists; low-phase length = max(low_period,1), latched at start. This gives an arbitrary duty cycle.
- Undefined: the low_period port is absent; low-phase length equals high-phase length (50% duty). All other behaviour is identical.

Test Plan:
- Basic burst: rst pulse, then half_period=5, num_cycles=3, start pulse at edge N.
  - signal high N..N+4, low N+5..N+9, repeated 3 times.
  - busy falls and done=1 at edge N+30; cycle_count=3.
- Zero half-period: half_period=0, num_cycles=2.
  - signal toggles every clock (H=1).
  - done at edge N+4; cycle_count=2.
- Continuous mode with stop: num_cycles=0, half_period=4, stop pulsed mid-high of the 7th period.
  - That period completes.
  - done at the end of its low phase; cycle_count=7; no further toggles.
- Reset and config stability:
  - rst asserted at the midpoint of a burst: signal, busy, done and cycle_count go to 0 without waiting for a clock edge, and no done pulse follows.
  - Separately, change half_period from 3 to 9 while busy: phase length stays 3.
- Handshake edges:
  - start held high continuously with half_period=2, num_cycles=1: bursts repeat with a 1-clock IDLE gap (done high during the gap).
  - start+stop together in IDLE: burst runs normally.
- SQW_DUTY_EN build: half_period=2, low_period=6, num_cycles=2.
  - Pattern per period is 2 clocks high, 6 clocks low.
  - done at edge N+16.
